// File: rtl/gigatron_video_pkg.sv
// Shared timing defaults, pixel type and helpers for the Gigatron-native video path.
package gigatron_video_pkg;

    localparam int unsigned GT_H_SYNC     = 24;
    localparam int unsigned GT_H_BACK     = 12;
    localparam int unsigned GT_H_ACTIVE   = 160;
    localparam int unsigned GT_H_TOTAL    = 200;
    localparam int unsigned GT_V_SYNC     = 2;
    localparam int unsigned GT_V_BACK     = 29;
    localparam int unsigned GT_V_ACTIVE   = 480;
    localparam int unsigned GT_V_TOTAL    = 521;
    localparam int unsigned GT_ROW_REPEAT = 4;

    typedef struct packed {
        logic [1:0] b;
        logic [1:0] g;
        logic [1:0] r;
    } gt_pixel_t;

    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

    // True when pos lies in [sync+back, sync+back+active).
    function automatic logic in_active(input int unsigned pos, input int unsigned sync,
                                       input int unsigned back, input int unsigned active);
        return (pos >= sync + back) && (pos < sync + back + active);
    endfunction

endpackage

// File: rtl/gigatron_video_timing.sv
// Horizontal/vertical counters (S0) and registered sync/active/frame-start flags (S1).
module gigatron_video_timing
    import gigatron_video_pkg::*;
#(
    parameter int unsigned H_SYNC   = GT_H_SYNC,
    parameter int unsigned H_BACK   = GT_H_BACK,
    parameter int unsigned H_ACTIVE = GT_H_ACTIVE,
    parameter int unsigned H_TOTAL  = GT_H_TOTAL,
    parameter int unsigned V_SYNC   = GT_V_SYNC,
    parameter int unsigned V_BACK   = GT_V_BACK,
    parameter int unsigned V_ACTIVE = GT_V_ACTIVE,
    parameter int unsigned V_TOTAL  = GT_V_TOTAL
) (
    input  logic       clk1,
    input  logic       reset_n,
    output logic [7:0] h,
    output logic [9:0] v,
    output logic       active,
    output logic       hs_n_s1,
    output logic       vs_n_s1,
    output logic       active_s1,
    output logic       frame_start_s1
);

    logic h_wrap;
    logic v_wrap;

    always_comb begin
        h_wrap = (h == 8'(H_TOTAL - 1));
        v_wrap = (v == 10'(V_TOTAL - 1));
        active = in_active(32'(h), H_SYNC, H_BACK, H_ACTIVE)
              && in_active(32'(v), V_SYNC, V_BACK, V_ACTIVE);
    end

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            h              <= '0;
            v              <= '0;
            hs_n_s1        <= 1'b1;
            vs_n_s1        <= 1'b1;
            active_s1      <= 1'b0;
            frame_start_s1 <= 1'b0;
        end else begin
            h <= h_wrap ? '0 : h + 8'd1;
            if (h_wrap) begin
                v <= v_wrap ? '0 : v + 10'd1;
            end
            hs_n_s1        <= !(32'(h) < H_SYNC);
            vs_n_s1        <= !(32'(v) < V_SYNC);
            active_s1      <= active;
            frame_start_s1 <= (h == '0) && (v == '0);
        end
    end

endmodule

// File: rtl/gigatron_vgagen.sv
// Gigatron-native video transmitter: framebuffer addressing, RAM latency alignment,
// colour-bar pattern mux and registered VGA pins (3-cycle counter-to-pin latency).
module gigatron_vgagen
    import gigatron_video_pkg::*;
#(
    parameter int unsigned H_SYNC     = GT_H_SYNC,
    parameter int unsigned H_BACK     = GT_H_BACK,
    parameter int unsigned H_ACTIVE   = GT_H_ACTIVE,
    parameter int unsigned H_TOTAL    = GT_H_TOTAL,
    parameter int unsigned V_SYNC     = GT_V_SYNC,
    parameter int unsigned V_BACK     = GT_V_BACK,
    parameter int unsigned V_ACTIVE   = GT_V_ACTIVE,
    parameter int unsigned V_TOTAL    = GT_V_TOTAL,
    parameter int unsigned ROW_REPEAT = GT_ROW_REPEAT
) (
    input  logic        clk1,
    input  logic        reset_n,
    input  logic        pattern_en,
    output logic [14:0] fb_addr,
    input  logic [5:0]  fb_rdata,
    output logic [3:0]  gigatron_vga_r,
    output logic [3:0]  gigatron_vga_g,
    output logic [3:0]  gigatron_vga_b,
    output logic        gigatron_vga_hs,
    output logic        gigatron_vga_vs,
    output logic        frame_start
);

    localparam int unsigned ROW_SHIFT = $clog2(ROW_REPEAT);
    localparam logic [7:0]  H_FIRST   = 8'(H_SYNC + H_BACK);
    localparam logic [9:0]  V_FIRST   = 10'(V_SYNC + V_BACK);

    logic [7:0] h;
    logic [9:0] v;
    logic       active;
    logic       hs_n_s1, vs_n_s1, active_s1, fs_s1, pattern_s1;
    logic       hs_n_s2, vs_n_s2, active_s2, fs_s2, pattern_s2;
    logic [7:0] col;
    logic [6:0] row;
    logic [2:0] bar;
    gt_pixel_t  bar_px;
    gt_pixel_t  bar_s2;
    gt_pixel_t  px;

    gigatron_video_timing #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_timing (
        .clk1           (clk1),
        .reset_n        (reset_n),
        .h              (h),
        .v              (v),
        .active         (active),
        .hs_n_s1        (hs_n_s1),
        .vs_n_s1        (vs_n_s1),
        .active_s1      (active_s1),
        .frame_start_s1 (fs_s1)
    );

    // Bars are 20 columns wide; the S1 column is the low byte of the registered address.
    always_comb begin
        col      = h - H_FIRST;
        row      = 7'((v - V_FIRST) >> ROW_SHIFT);
        bar      = 3'(fb_addr[7:0] / 8'd20);
        bar_px.r = {2{bar[0]}};
        bar_px.g = {2{bar[1]}};
        bar_px.b = {2{bar[2]}};
        px       = pattern_s2 ? bar_s2 : gt_pixel_t'(fb_rdata);
    end

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr         <= '0;
            pattern_s1      <= 1'b0;
            hs_n_s2         <= 1'b1;
            vs_n_s2         <= 1'b1;
            active_s2       <= 1'b0;
            fs_s2           <= 1'b0;
            pattern_s2      <= 1'b0;
            bar_s2          <= '0;
            gigatron_vga_hs <= 1'b1;
            gigatron_vga_vs <= 1'b1;
            frame_start     <= 1'b0;
            gigatron_vga_r  <= '0;
            gigatron_vga_g  <= '0;
            gigatron_vga_b  <= '0;
        end else begin
            if (active) begin
                fb_addr <= {row, col};
            end
            pattern_s1      <= pattern_en;
            hs_n_s2         <= hs_n_s1;
            vs_n_s2         <= vs_n_s1;
            active_s2       <= active_s1;
            fs_s2           <= fs_s1;
            pattern_s2      <= pattern_s1;
            bar_s2          <= bar_px;
            gigatron_vga_hs <= hs_n_s2;
            gigatron_vga_vs <= vs_n_s2;
            frame_start     <= fs_s2;
            gigatron_vga_r  <= active_s2 ? expand2(px.r) : '0;
            gigatron_vga_g  <= active_s2 ? expand2(px.g) : '0;
            gigatron_vga_b  <= active_s2 ? expand2(px.b) : '0;
        end
    end

endmodule

// File: tb/tb_gigatron_vgagen.sv
// Scoreboarded bench: dut_a uses default timing, dut_b a short-line variant so full frames fit.
module tb_gigatron_vgagen;

    localparam int HS_P[2] = '{24, 4};
    localparam int HB_P[2] = '{12, 2};
    localparam int HA_P[2] = '{160, 8};
    localparam int HT_P[2] = '{200, 16};
    localparam int VS_P[2] = '{2, 2};
    localparam int VB_P[2] = '{29, 29};
    localparam int VA_P[2] = '{480, 480};
    localparam int VT_P[2] = '{521, 521};

    typedef struct packed { logic hs; logic vs; logic fs; logic [3:0] r; logic [3:0] g; logic [3:0] b; } pins_t;
    typedef struct packed { int h; int v; pins_t p; } pexp_t;
    typedef struct packed { int h; int v; logic [14:0] a; } aexp_t;
    typedef struct packed { int inst; int v; int h; logic [14:0] a; } avec_t;
    typedef struct packed { int inst; int v; int h; logic [11:0] rgb; } pvec_t;

    localparam pins_t IDLE = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};

    localparam int NA = 9;
    localparam avec_t ATAB[NA] = '{
        '{0, 31, 36, 15'h0000}, '{0, 34, 195, 15'h009F}, '{0, 35, 36, 15'h0100},
        '{0, 35, 195, 15'h019F}, '{0, 35, 199, 15'h019F}, '{0, 36, 35, 15'h019F},
        '{1, 510, 6, 15'h7700}, '{1, 510, 13, 15'h7707}, '{1, 511, 0, 15'h7707}
    };
    localparam int NP = 16;
    localparam pvec_t PTAB[NP] = '{
        '{0, 31, 36, 12'hA5F}, '{0, 31, 195, 12'hA5F}, '{0, 31, 35, 12'h000},
        '{0, 31, 196, 12'h000}, '{0, 30, 100, 12'h000}, '{0, 32, 0, 12'h000},
        '{0, 37, 36, 12'h000}, '{0, 37, 55, 12'h000}, '{0, 37, 56, 12'hF00},
        '{0, 37, 75, 12'hF00}, '{0, 37, 76, 12'h0F0}, '{0, 37, 176, 12'hFFF},
        '{0, 37, 195, 12'hFFF}, '{1, 510, 6, 12'hF5F}, '{1, 510, 13, 12'h00F},
        '{1, 511, 8, 12'h000}
    };

    logic        clk1 = 1'b0;
    logic        rst_n[2];
    logic        pat[2];
    logic [14:0] addr[2];
    logic [5:0]  rdata[2];
    logic [3:0]  r[2], g[2], b[2];
    logic        hs[2], vs[2], fs[2];

    int compared = 0;
    int mismatched = 0;
    int mh[2], mv[2];
    logic [14:0] maddr[2];
    bit started[2];
    pexp_t pq[2][$];
    aexp_t aq[2][$];
    int ahits[NA];
    int phits[NP];
    int edge_n[2], hfall[2], vfall[2], vper[2];
    logic phs[2], pvs[2];

    always #80 clk1 = ~clk1;

    gigatron_vgagen dut_a (
        .clk1(clk1), .reset_n(rst_n[0]), .pattern_en(pat[0]), .fb_addr(addr[0]), .fb_rdata(rdata[0]),
        .gigatron_vga_r(r[0]), .gigatron_vga_g(g[0]), .gigatron_vga_b(b[0]),
        .gigatron_vga_hs(hs[0]), .gigatron_vga_vs(vs[0]), .frame_start(fs[0])
    );

    gigatron_vgagen #(.H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_TOTAL(16)) dut_b (
        .clk1(clk1), .reset_n(rst_n[1]), .pattern_en(pat[1]), .fb_addr(addr[1]), .fb_rdata(rdata[1]),
        .gigatron_vga_r(r[1]), .gigatron_vga_g(g[1]), .gigatron_vga_b(b[1]),
        .gigatron_vga_hs(hs[1]), .gigatron_vga_vs(vs[1]), .frame_start(fs[1])
    );

    function automatic logic [5:0] ram_fn(input int i, input logic [14:0] a);
        return (i == 0) ? 6'b110110 : (a[5:0] ^ a[13:8]);
    endfunction

    function automatic void check(input string name, input int i, input int v, input int h,
                                  input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d v=%0d h=%0d: got 0x%0h, expected 0x%0h", name, i, v, h, got, exp);
        end
    endfunction

    function automatic pins_t pins_of(input int i);
        return '{hs: hs[i], vs: vs[i], fs: fs[i], r: r[i], g: g[i], b: b[i]};
    endfunction

    // Synchronous RAM model: data one clock after the address.
    always @(posedge clk1) begin
        for (int i = 0; i < 2; i++) rdata[i] <= ram_fn(i, addr[i]);
    end

    // Expected-value producer: one entry per counter state.
    always @(negedge clk1) begin
        for (int i = 0; i < 2; i++) begin
            pins_t e;
            logic [14:0] na;
            logic [5:0] d;
            bit act;
            int col, row, k;
            if (!rst_n[i]) begin
                pq[i].delete();
                aq[i].delete();
                mh[i] = 0;
                mv[i] = 0;
                maddr[i] = '0;
                started[i] = 0;
            end else begin
                if (!started[i]) begin
                    pq[i].push_back('{h: -1, v: -1, p: IDLE});
                    pq[i].push_back('{h: -1, v: -1, p: IDLE});
                    started[i] = 1;
                end
                act = (mh[i] >= HS_P[i] + HB_P[i]) && (mh[i] < HS_P[i] + HB_P[i] + HA_P[i])
                   && (mv[i] >= VS_P[i] + VB_P[i]) && (mv[i] < VS_P[i] + VB_P[i] + VA_P[i]);
                col = mh[i] - (HS_P[i] + HB_P[i]);
                row = (mv[i] - (VS_P[i] + VB_P[i])) / 4;
                na = {7'(row), 8'(col)};
                if (act) maddr[i] = na;
                aq[i].push_back('{h: mh[i], v: mv[i], a: maddr[i]});
                e = IDLE;
                e.hs = !(mh[i] < HS_P[i]);
                e.vs = !(mv[i] < VS_P[i]);
                e.fs = (mh[i] == 0) && (mv[i] == 0);
                if (act) begin
                    if (pat[i]) begin
                        k = col / 20;
                        e.r = {4{k[0]}};
                        e.g = {4{k[1]}};
                        e.b = {4{k[2]}};
                    end else begin
                        d = ram_fn(i, na);
                        e.r = {d[1:0], d[1:0]};
                        e.g = {d[3:2], d[3:2]};
                        e.b = {d[5:4], d[5:4]};
                    end
                end
                pq[i].push_back('{h: mh[i], v: mv[i], p: e});
                mh[i]++;
                if (mh[i] == HT_P[i]) begin
                    mh[i] = 0;
                    mv[i]++;
                    if (mv[i] == VT_P[i]) mv[i] = 0;
                end
            end
        end
    end

    // Monitor: pops one address and one pin expectation per clock per DUT.
    always @(posedge clk1) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            pexp_t pe;
            aexp_t ae;
            if (rst_n[i]) begin
                if (aq[i].size() > 0) begin
                    ae = aq[i].pop_front();
                    check("fb_addr", i, ae.v, ae.h, 32'(addr[i]), 32'(ae.a));
                    for (int t = 0; t < NA; t++) begin
                        if (ATAB[t].inst == i && ATAB[t].v == ae.v && ATAB[t].h == ae.h) begin
                            ahits[t]++;
                            check("fb_addr_vec", i, ae.v, ae.h, 32'(addr[i]), 32'(ATAB[t].a));
                        end
                    end
                end
                if (pq[i].size() > 0) begin
                    pe = pq[i].pop_front();
                    check("pins", i, pe.v, pe.h, 32'(pins_of(i)), 32'(pe.p));
                    for (int t = 0; t < NP; t++) begin
                        if (PTAB[t].inst == i && PTAB[t].v == pe.v && PTAB[t].h == pe.h) begin
                            phits[t]++;
                            check("rgb_vec", i, pe.v, pe.h, 32'({r[i], g[i], b[i]}), 32'(PTAB[t].rgb));
                        end
                    end
                end
            end
        end
    end

    // Sync pulse geometry measured directly on the pins.
    always @(posedge clk1) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                edge_n[i] = 0;
                hfall[i] = -1;
                vfall[i] = -1;
                phs[i] = 1'b1;
                pvs[i] = 1'b1;
            end else begin
                edge_n[i]++;
                if (phs[i] && !hs[i]) begin
                    if (hfall[i] < 0) check("hs_first_fall", i, 0, 0, 32'(edge_n[i]), 32'd3);
                    else check("hs_period", i, 0, 0, 32'(edge_n[i] - hfall[i]), 32'(HT_P[i]));
                    hfall[i] = edge_n[i];
                end
                if (!phs[i] && hs[i]) check("hs_low_width", i, 0, 0, 32'(edge_n[i] - hfall[i]), 32'(HS_P[i]));
                if (pvs[i] && !vs[i]) begin
                    if (vfall[i] < 0) check("vs_first_fall", i, 0, 0, 32'(edge_n[i]), 32'd3);
                    else begin
                        check("vs_period", i, 0, 0, 32'(edge_n[i] - vfall[i]), 32'(HT_P[i] * VT_P[i]));
                        vper[i]++;
                    end
                    vfall[i] = edge_n[i];
                end
                if (!pvs[i] && vs[i])
                    check("vs_low_width", i, 0, 0, 32'(edge_n[i] - vfall[i]), 32'(HT_P[i] * VS_P[i]));
                if (fs[i] || (pvs[i] && !vs[i]))
                    check("frame_start_align", i, 0, 0, 32'(fs[i]), 32'(pvs[i] && !vs[i]));
                phs[i] = hs[i];
                pvs[i] = vs[i];
            end
        end
    end

    task automatic wait_state(input int i, input int v, input int h, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk1);
            #2;
            if (mv[i] == v && mh[i] == h) return;
        end
        check("wait_timeout", i, v, h, 32'd0, 32'd1);
    endtask

    initial begin
        #(50000 * 160);
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        pat[0] = 1'b0;
        pat[1] = 1'b0;
        repeat (3) @(posedge clk1);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("reset_pins", i, 0, 0, 32'(pins_of(i)), 32'(IDLE));
            check("reset_addr", i, 0, 0, 32'(addr[i]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        wait_state(0, 36, 0, 10000);
        pat[0] = 1'b1;
        wait_state(0, 41, 0, 2000);
        pat[0] = 1'b0;

        wait_state(0, 200, 100, 40000);
        #10;
        rst_n[0] = 1'b0;
        #1;
        check("midframe_reset_pins", 0, 200, 100, 32'(pins_of(0)), 32'(IDLE));
        check("midframe_reset_addr", 0, 200, 100, 32'(addr[0]), 32'd0);
        repeat (5) @(posedge clk1);
        #2;
        rst_n[0] = 1'b1;
        wait_state(0, 3, 0, 1000);
        repeat (4) @(posedge clk1);

        check("vs_period_seen", 1, 0, 0, 32'(vper[1] > 0), 32'd1);
        for (int t = 0; t < NA; t++) check("addr_vec_hit", ATAB[t].inst, ATAB[t].v, ATAB[t].h, 32'(ahits[t] > 0), 32'd1);
        for (int t = 0; t < NP; t++) check("rgb_vec_hit", PTAB[t].inst, PTAB[t].v, PTAB[t].h, 32'(phits[t] > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
